// File: rtl/bit_serial_pkg.sv
// Shared types and width limits for the bit-serial adder.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // True when an operand width can be handled by the serial datapath.
    function automatic bit width_legal(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/sum_bit_cell.sv
// Combinational 1-bit full adder; the only arithmetic cell in the serial adder.
module sum_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carryout
);

    assign sum      = a ^ b ^ cin;
    assign carryout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one operand bit per clock through a single full-adder cell,
// LSB first, with the carry held in a register between cycles.
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    generate
        if (!width_legal(WIDTH)) begin : g_bad_width
            $error("bit_serial_adder: WIDTH must be in 2..32");
        end
    endgenerate

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             msb_carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             cell_s;
    logic             cell_c;

    sum_bit_cell u_cell (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .cin      (carry_q),
        .sum      (cell_s),
        .carryout (cell_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH cycles of RUN, hold in DONE until consumed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)            state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST)   state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Serial datapath: operands shift out LSB first, sum bits enter at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh        <= '0;
            b_sh        <= '0;
            sum_sh      <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            msb_carry_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                a_sh    <= a;
                b_sh    <= b;
                carry_q <= cin;
                cnt_q   <= '0;
                sum_sh  <= '0;
            end else if (state_q == RUN) begin
                sum_sh  <= {cell_s, sum_sh[WIDTH-1:1]};
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                carry_q <= cell_c;
                // The cell's carry on the second-to-last bit is the carry into the MSB.
                if (cnt_q == CNT_MSB) begin
                    msb_carry_q <= cell_c;
                end
                if (cnt_q == CNT_LAST) begin
                    cout_q <= cell_c;
                    ovf_q  <= cell_c ^ msb_carry_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign sum       = sum_sh;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed testbench for bit_serial_adder (WIDTH=8).
module tb_bit_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int n_tests;
    int n_fail;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one operation, count edges to out_valid, check the result.
    // Leaves the DUT in DONE, sampled 1ns after the edge that entered it.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic [7:0] es, input logic ec,
                          input logic eo);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = ~va;
        b        = ~vb;
        cin      = ~vc;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held_sum;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0x5A+0x3C: positive+positive gives negative -> overflow.
        run_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("done_one_cycle_valid", 32'(out_valid), 32'd0);
        chk("done_one_cycle_ready", 32'(in_ready), 32'd1);

        run_op("opff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge clk); #1;
        run_op("opffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        run_op("op8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN.
        a        = 8'h5A;
        b        = 8'h3C;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("arst_no_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        run_op("op1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Backpressure: result must hold while inputs churn.
        out_ready = 1'b0;
        run_op("op7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        held_sum = sum;
        for (int i = 0; i < 5; i++) begin
            a        = 8'($urandom);
            b        = 8'($urandom);
            in_valid = ~in_valid;
            @(posedge clk); #1;
            chk("bp_sum", 32'(sum), 32'h80);
            chk("bp_cout", 32'(cout), 32'd0);
            chk("bp_ovf", 32'(ovf), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_held_sum", 32'(held_sum), 32'h80);
        run_op("op0101", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
